// File: rtl/ifetch_pkg.sv
// Shared encodings and constants for the instruction fetch unit.
package ifetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_RSP   = 3'd2,
    S_STALL = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/ifetch_buf.sv
// One-entry valid/ready holding register between fetch and decode.
// Holds NOP whenever empty so the decoder always sees a harmless word.
module ifetch_buf
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        pop_i,
  input  logic        flush_i,
  input  logic [31:0] ld_data_i,
  input  logic [31:0] ld_pc_i,
  output logic [31:0] prog_o,
  output logic [31:0] prog_pc_o,
  output logic        prog_valid_o
);

  logic [31:0] data_q, pc_q;
  logic        vld_q;

  // prog_pc is left alone on pop/flush; only the word falls back to NOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= NOP;
      pc_q   <= RESET_PC;
      vld_q  <= 1'b0;
    end else if (flush_i || pop_i) begin
      data_q <= NOP;
      vld_q  <= 1'b0;
    end else if (load_i) begin
      data_q <= ld_data_i;
      pc_q   <= ld_pc_i;
      vld_q  <= 1'b1;
    end
  end

  assign prog_o       = data_q;
  assign prog_pc_o    = pc_q;
  assign prog_valid_o = vld_q;

endmodule

// File: rtl/ifetch.sv
// RV32I instruction fetch: PC, single-outstanding imem req/gnt/rvalid, redirect flush.
// Optional IFETCH_MISALIGN_EN: misaligned jump targets are trapped and fetch halts.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] prog,
  output logic [31:0] prog_pc,
  output logic        prog_valid,
  input  logic        prog_ready,
  input  logic        jmpe,
  input  logic [31:0] jmp_addr
`ifdef IFETCH_MISALIGN_EN
  ,
  output logic        fetch_misalign,
  output logic [31:0] fetch_bad_addr
`endif
);

  state_e      state_q, state_d;
  logic        drop_q, drop_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q;
  logic        buf_load, buf_pop, buf_flush;
  logic        redir, mis;

  assign redir = jmpe & (state_q != S_HALT);

`ifdef IFETCH_MISALIGN_EN
  logic        mis_q;
  logic [31:0] bad_q;

  assign mis            = redir & (|jmp_addr[1:0]);
  assign fetch_misalign = mis_q;
  assign fetch_bad_addr = bad_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_q <= 1'b0;
      bad_q <= '0;
    end else if (mis) begin
      mis_q <= 1'b1;
      bad_q <= jmp_addr;
    end
  end
`else
  logic unused_jmp_lo;
  assign unused_jmp_lo = ^jmp_addr[1:0];
  assign mis           = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    drop_d    = drop_q;
    pc_d      = pc_q;
    buf_load  = 1'b0;
    buf_pop   = 1'b0;
    buf_flush = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ:  if (imem_gnt) state_d = S_RSP;
      S_RSP: begin
        if (imem_rvalid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            buf_load = 1'b1;
            pc_d     = pc_q + PC_INC;
            state_d  = S_STALL;
          end
        end
      end
      S_STALL: begin
        if (prog_valid && prog_ready) begin
          buf_pop = 1'b1;
          state_d = S_REQ;
        end
      end
      default: ;
    endcase

    // A redirect overrides the normal flow; in REQ the grant still moves us to RSP.
    if (redir) begin
      pc_d      = {jmp_addr[31:2], 2'b00};
      buf_flush = 1'b1;
      buf_load  = 1'b0;
      case (state_q)
        S_REQ: drop_d = 1'b1;
        S_RSP: begin
          if (imem_rvalid) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            drop_d = 1'b1;
          end
        end
        default: state_d = S_REQ;
      endcase
    end

    if (mis) begin
      state_d   = S_HALT;
      pc_d      = pc_q;
      drop_d    = 1'b0;
      buf_load  = 1'b0;
      buf_flush = 1'b1;
    end
  end

  // Request address is frozen while in REQ so it cannot move before the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      drop_q  <= 1'b0;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      pc_q    <= pc_d;
      if (state_q != S_REQ) addr_q <= pc_d;
    end
  end

  assign imem_req  = (state_q == S_REQ);
  assign imem_addr = addr_q;

  ifetch_buf #(.RESET_PC(RESET_PC)) u_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (buf_load),
    .pop_i        (buf_pop),
    .flush_i      (buf_flush),
    .ld_data_i    (imem_rdata),
    .ld_pc_i      (pc_q),
    .prog_o       (prog),
    .prog_pc_o    (prog_pc),
    .prog_valid_o (prog_valid)
  );

endmodule
